// File: rtl/communication_initiator.sv
// communication_initiator
//
// Initiating end of a session link. Serialises a stream of bytes onto a UART-style
// 8N1 line (LSB first) and brackets the whole stream with one session: a one-cycle
// initiated pulse at the first start bit and a one-cycle ended pulse after the stop
// bit of the byte flagged as last.
//
// Ports:
//   clk                        sole clock, rising edge
//   rst_n                      asynchronous active-low reset
//   byte_valid_i               byte offered on byte_data_i / byte_last_i
//   byte_data_i[7:0]           payload byte, captured on handshake
//   byte_last_i                byte closes the session, captured on handshake
//   byte_ready_o               byte accepted this cycle if byte_valid_i is high
//   tx_o                       serial line, idles high
//   communication_initiated_o  pulse in the first start-bit cycle of a session
//   communication_ended_o      pulse in the cycle after the session's last stop bit
//   is_communicating_o         high from the initiated pulse through the last stop bit
module communication_initiator #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    input  logic       byte_last_i,
    output logic       byte_ready_o,
    output logic       tx_o,
    output logic       communication_initiated_o,
    output logic       communication_ended_o,
    output logic       is_communicating_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            last_q, last_d;
    logic            init_q, init_d;
    logic            ended_q, ended_d;

    logic            bit_end;
    logic            handshake;

    assign bit_end   = (cnt_q == CntMax);
    assign handshake = byte_valid_i & byte_ready_o;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            init_q  <= 1'b0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            init_q  <= init_d;
            ended_q <= ended_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        init_d  = 1'b0;
        ended_d = 1'b0;

        // byte_ready_o is low whenever the shift register is in use, so loading here
        // can never clobber an in-flight byte.
        if (handshake) begin
            shift_d = byte_data_i;
            last_d  = byte_last_i;
        end

        unique case (state_q)
            StIdle: begin
                if (handshake) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    init_d  = 1'b1;
                end
            end
            StGap: begin
                if (handshake) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (last_q) begin
                        state_d = StIdle;
                        ended_d = 1'b1;
                    end else if (handshake) begin
                        // Back-to-back byte: same session, no new initiated pulse.
                        state_d = StStart;
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs, decoded from registered state only
    always_comb begin
        byte_ready_o = 1'b0;
        tx_o         = 1'b1;
        unique case (state_q)
            StIdle:  byte_ready_o = 1'b1;
            StGap:   byte_ready_o = 1'b1;
            StStart: tx_o = 1'b0;
            StData:  tx_o = shift_q[0];
            StStop:  byte_ready_o = bit_end & ~last_q;
            default: ;
        endcase
        communication_initiated_o = init_q;
        communication_ended_o     = ended_q;
        is_communicating_o        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_communication_initiator.sv
// Bench for communication_initiator. A frame-position model predicts every output
// each cycle: a frame is 10*C cycles (start, 8 data bits LSB first, stop), sessions
// open on an accepted byte outside a session and close after a last byte.
module tb_communication_initiator;

    localparam int unsigned C        = 4;
    localparam int unsigned FrameLen = 10 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready;
    logic       tx;
    logic       comm_init;
    logic       comm_end;
    logic       is_comm;

    communication_initiator #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .byte_valid_i             (byte_valid),
        .byte_data_i              (byte_data),
        .byte_last_i              (byte_last),
        .byte_ready_o             (byte_ready),
        .tx_o                     (tx),
        .communication_initiated_o(comm_init),
        .communication_ended_o    (comm_end),
        .is_communicating_o       (is_comm)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit         m_active;
    bit         m_sess;
    bit         m_new;
    bit         m_last;
    bit         m_ended;
    bit         m_hs;
    logic [7:0] m_byte;
    int         m_pos;

    logic e_tx, e_ready, e_comm, e_init, e_ended;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_sess   = 0;
        m_new    = 0;
        m_last   = 0;
        m_ended  = 0;
        m_pos    = 0;
        m_byte   = '0;
    endtask

    task automatic model_expect();
        int idx;
        if (m_active) begin
            idx     = m_pos / C;
            if (idx == 0)      e_tx = 1'b0;
            else if (idx <= 8) e_tx = m_byte[idx-1];
            else               e_tx = 1'b1;
            e_ready = (m_pos == FrameLen - 1) && !m_last;
            e_comm  = 1'b1;
            e_init  = m_new && (m_pos == 0);
            e_ended = 1'b0;
        end else begin
            e_tx    = 1'b1;
            e_ready = 1'b1;
            e_comm  = m_sess;
            e_init  = 1'b0;
            e_ended = m_ended;
        end
    endtask

    task automatic model_edge(input bit hs, input logic [7:0] d, input logic l);
        m_ended = 0;
        if (m_active) begin
            if (m_pos == FrameLen - 1) begin
                if (hs) begin
                    m_pos  = 0;
                    m_byte = d;
                    m_last = l;
                    m_new  = 0;
                end else begin
                    m_active = 0;
                    if (m_last) begin
                        m_sess  = 0;
                        m_ended = 1;
                    end
                end
            end else begin
                m_pos++;
            end
        end else if (hs) begin
            m_active = 1;
            m_pos    = 0;
            m_byte   = d;
            m_last   = l;
            m_new    = !m_sess;
            m_sess   = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_tx"},    tx,         e_tx);
        chk({tag, "_ready"}, byte_ready, e_ready);
        chk({tag, "_comm"},  is_comm,    e_comm);
        chk({tag, "_init"},  comm_init,  e_init);
        chk({tag, "_ended"}, comm_end,   e_ended);
    endtask

    // Check the current cycle, advance the model across the edge, then step the clock.
    task automatic cycle(input string tag);
        model_expect();
        check_all(tag);
        m_hs = (byte_valid === 1'b1) && e_ready;
        model_edge(m_hs, byte_data, byte_last);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        byte_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            byte_data = 8'($urandom);
            byte_last = 1'($urandom);
            cycle(tag);
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic l, input string tag);
        bit done;
        done       = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        for (int i = 0; i < 200 && !done; i++) begin
            cycle(tag);
            done = m_hs;
        end
        n_cmp++;
        assert (done) else begin
            n_fail++;
            $error("FAIL %s_accept observed=not-accepted expected=accepted", tag);
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        byte_last  = 1'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        byte_last  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        model_expect();
        check_all("reset");
        rst_n = 1'b1;

        // Single last byte 0xA5
        idle(2, "pre");
        offer(8'hA5, 1'b1, "a5");
        chk("a5_init_direct", comm_init, 1'b1);
        idle(45, "a5");

        // Back-to-back 0x01 then 0x80 with valid held high
        offer(8'h01, 1'b0, "b2b0");
        offer(8'h80, 1'b1, "b2b1");
        idle(45, "b2b");

        // Gap between 0x55 and 0xFF
        offer(8'h55, 1'b0, "gap0");
        idle(FrameLen + 7, "gap");
        chk("gap_comm_direct", is_comm, 1'b1);
        offer(8'hFF, 1'b1, "gap1");
        idle(45, "gap1");

        // Reset mid-frame, then a fresh session
        offer(8'h3C, 1'b1, "rst0");
        idle(14, "rst0");
        rst_n = 1'b0;
        #1;
        model_reset();
        model_expect();
        check_all("midrst");
        #1;
        rst_n = 1'b1;
        idle(3, "postrst");
        offer(8'hC3, 1'b1, "rst1");
        chk("rst1_init_direct", comm_init, 1'b1);
        idle(45, "rst1");

        // Inputs toggling while the byte is in flight
        offer(8'h96, 1'b1, "tog");
        for (int i = 0; i < FrameLen - 2; i++) begin
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            byte_last  = 1'($urandom);
            cycle("tog");
        end
        idle(10, "tog");

        // New byte offered in the ended cycle
        offer(8'h11, 1'b1, "endhs0");
        idle(FrameLen, "endhs0");
        chk("endhs_ended_direct", comm_end, 1'b1);
        chk("endhs_comm_direct", is_comm, 1'b0);
        offer(8'h22, 1'b1, "endhs1");
        chk("endhs1_init_direct", comm_init, 1'b1);
        idle(45, "endhs1");

        // Randomized byte stream with random gaps and session ends
        for (int k = 0; k < 25; k++) begin
            idle($urandom_range(0, 12), "rnd_gap");
            offer(8'($urandom), ($urandom_range(0, 2) == 0), "rnd");
        end
        idle(FrameLen + 20, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
